pb_bounce_gen: RTL and testbench
================================

// Module: pb_bounce_gen
// PURPOSE
//   Synthesizable mechanical-pushbutton emulator: on command, drives pb_out
//   to a new level through a burst of contact-bounce glitches, then holds it.
//   It is the transmit end of the button interface and feeds debouncer inputs
//   in on-board self-test and simulation, in place of a physical key.
// PARAMETERS
//   BOUNCE_MAX  3        max bounce pairs K per transition (K in 0..BOUNCE_MAX)
//   GLITCH_W    4        segment-length field width; segment = 1..2^GLITCH_W cycles
//   SETTLE_CYC  20       stable cycles after final edge before done
//   LFSR_SEED   16'hACE1 LFSR reset value; 0 is forced to 16'h0001
// PORTS
//   clk      in   1  clock
//   rst      in   1  asynchronous, active-low reset
//   start    in   1  1-cycle request to begin a transition
//   level    in   1  target pb level, sampled with start
//   pb_out   out  1  emulated bouncy button line
//   busy     out  1  high while state != IDLE
//   done     out  1  1-cycle pulse when the transition has settled
// BEHAVIOUR
//   Reset: pb_out=0, busy=0, done=0, state=IDLE, lfsr=LFSR_SEED (0->1).
//   LFSR: 16-bit Galois, mask 16'hB400, advances every clock, even when idle.
//   States: IDLE, BOUNCE, SETTLE.
//   IDLE: start && level!=pb_out -> BOUNCE; at that edge (E0) pb_out toggles,
//     K = lfsr mod (BOUNCE_MAX+1), toggles_left = 2K, seg_cnt = lfsr[GLITCH_W-1:0]+1.
//   IDLE: start && level==pb_out -> no toggle; done pulses next cycle.
//   BOUNCE: seg_cnt decrements each cycle; on expiry, if toggles_left>0:
//     toggle pb_out, decrement toggles_left, reload seg_cnt from current lfsr;
//     after last toggle (toggles_left==0) -> SETTLE, settle_cnt=SETTLE_CYC.
//   Total toggles per transition = 2K+1 (odd): final pb_out == level.
//   SETTLE: pb_out constant; after SETTLE_CYC cycles -> IDLE with done=1
//     for exactly one cycle; busy falls at the same edge.
//   start while busy: ignored (no queueing, level not resampled).
//   start in the done cycle: accepted (state is already IDLE).
//   Widths: seg_cnt GLITCH_W+1 bits; toggles_left clog2(2*BOUNCE_MAX+1);
//     settle_cnt clog2(SETTLE_CYC+1).
//   Reset mid-operation: immediate return to reset values; no done pulse.
// CONFIGURATION
//   BOUNCE_FIXED_EN defined: K=BOUNCE_MAX always, every segment = 2^GLITCH_W
//     cycles; timing fully deterministic (LFSR still runs, unused).
//   Undefined: K and segment lengths pseudo-random from LFSR as above.
// STRUCTURE
//   Package pb_bounce_pkg: state encoding constants (IDLE/BOUNCE/SETTLE),
//     LFSR mask 16'hB400, default seed.
//   One sub-module: pb_lfsr16 (seed param, en, q[15:0]); FSM and counters
//     are in the top.
// TESTING (BOUNCE_MAX=2, GLITCH_W=2, SETTLE_CYC=20 unless noted)
//   1 BOUNCE_FIXED_EN; start,level=1 at edge E0 -> pb_out toggles at E0,E4,
//     E8,E12,E16 (5 edges), ends 1; done high for cycle after E36 only.
//   2 After 1: start,level=1 -> no pb_out edge, done next cycle, busy stays 0.
//   3 Start,level=0 during BOUNCE at E6 -> ignored; sequence of 1 unchanged.
//   4 rst low at E10 mid-bounce -> pb_out=0, busy=0, no done; next start works.
//   5 Random mode, 200 transitions with alternating level -> toggle count odd
//     and <=2*BOUNCE_MAX+1, every segment 1..4 cycles, final pb_out==level.
//   6 Chain to 4-cycle-window debouncer, SETTLE_CYC=8 -> debounced output
//     changes once per transition, never during the bounce burst.

Source files
------------

// File: rtl/pb_bounce_pkg.sv
// Shared definitions for the pushbutton bounce emulator.
// FSM state encoding plus the LFSR feedback mask and default seed.
package pb_bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/pb_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, feedback mask from the package).
// A zero seed would lock the register up, so it is replaced by 1.
module pb_lfsr16
  import pb_bounce_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // Shift right; when a one falls out of bit 0, fold it back in through the mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    end
  end

endmodule

// File: rtl/pb_bounce_gen.sv
// Mechanical pushbutton emulator: on start, moves pb_out to the requested
// level through a burst of 2K+1 toggles, then holds it for SETTLE_CYC cycles
// before pulsing done.
// Build option BOUNCE_FIXED_EN: K = BOUNCE_MAX and every glitch segment is
// 2^GLITCH_W cycles, giving fully deterministic timing.
module pb_bounce_gen
  import pb_bounce_pkg::*;
#(
  parameter int          BOUNCE_MAX = 3,
  parameter int          GLITCH_W   = 4,
  parameter int          SETTLE_CYC = 20,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level,
  output logic pb_out,
  output logic busy,
  output logic done
);

  localparam int SEG_W = GLITCH_W + 1;
  localparam int TOG_W = $clog2(2 * BOUNCE_MAX + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

  state_t             state, state_nx;
  logic               pb_nx, done_nx;
  logic [SEG_W-1:0]   seg_cnt, seg_nx, seg_load;
  logic [TOG_W-1:0]   tog_left, tog_nx, tog_load;
  logic [SET_W-1:0]   settle_cnt, settle_nx;
  logic [15:0]        lfsr_q;

  pb_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

`ifdef BOUNCE_FIXED_EN
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr_q;
  assign seg_load    = SEG_W'(2 ** GLITCH_W);
  assign tog_load    = TOG_W'(2 * BOUNCE_MAX);
`else
  logic [15:0] k_full;
  assign k_full   = lfsr_q % 16'(BOUNCE_MAX + 1);
  assign seg_load = SEG_W'(lfsr_q[GLITCH_W-1:0]) + SEG_W'(1);
  assign tog_load = TOG_W'({k_full, 1'b0});
`endif

  assign busy = (state != IDLE);

  // Next-state logic: launch a burst, time glitch segments, then settle.
  always_comb begin
    state_nx  = state;
    pb_nx     = pb_out;
    seg_nx    = seg_cnt;
    tog_nx    = tog_left;
    settle_nx = settle_cnt;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (level != pb_out) begin
            pb_nx  = ~pb_out;
            seg_nx = seg_load;
            tog_nx = tog_load;
            if (tog_load == '0) begin
              state_nx  = SETTLE;
              settle_nx = SETTLE_LOAD;
            end else begin
              state_nx = BOUNCE;
            end
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      BOUNCE: begin
        if (tog_left == '0) begin
          state_nx  = SETTLE;
          settle_nx = SETTLE_LOAD;
        end else if (seg_cnt <= SEG_W'(1)) begin
          pb_nx  = ~pb_out;
          tog_nx = tog_left - TOG_W'(1);
          seg_nx = seg_load;
          if (tog_left == TOG_W'(1)) begin
            state_nx  = SETTLE;
            settle_nx = SETTLE_LOAD;
          end
        end else begin
          seg_nx = seg_cnt - SEG_W'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt <= SET_W'(1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          settle_nx = settle_cnt - SET_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pb_out     <= 1'b0;
      seg_cnt    <= '0;
      tog_left   <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      pb_out     <= pb_nx;
      seg_cnt    <= seg_nx;
      tog_left   <= tog_nx;
      settle_cnt <= settle_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_pb_bounce_gen.sv
// Testbench for pb_bounce_gen (BOUNCE_MAX=2, GLITCH_W=2, SETTLE_CYC=20).
// The reference model schedules toggle and done times from the LFSR value at
// each event; with BOUNCE_FIXED_EN defined it uses the fixed K and segment length.
module tb_pb_bounce_gen;

  localparam int          BM     = 2;
  localparam int          GW     = 2;
  localparam int          SC     = 20;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic level = 1'b0;
  logic pb_out, busy, done;

  int total = 0;
  int bad = 0;

  // model state
  logic [15:0] m_lfsr;
  logic        m_pb, m_busy, m_done;
  int          m_cyc, m_next_toggle, m_remaining, m_done_at;

  pb_bounce_gen #(
    .BOUNCE_MAX (BM),
    .GLITCH_W   (GW),
    .SETTLE_CYC (SC),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .level  (level),
    .pb_out (pb_out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrNext(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int pickK(input logic [15:0] v);
`ifdef BOUNCE_FIXED_EN
    return BM;
`else
    return int'(v) % (BM + 1);
`endif
  endfunction

  function automatic int pickSeg(input logic [15:0] v);
`ifdef BOUNCE_FIXED_EN
    return 1 << GW;
`else
    return (int'(v) % (1 << GW)) + 1;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h (model cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic modelReset();
    m_lfsr      = SEED;
    m_pb        = 1'b0;
    m_busy      = 1'b0;
    m_done      = 1'b0;
    m_remaining = 0;
  endtask

  // Model behaviour at one rising clock edge, using pre-edge LFSR and inputs.
  task automatic modelEdge();
    int k;
    m_cyc++;
    if (!rst) begin
      modelReset();
      return;
    end
    m_done = 1'b0;
    if (!m_busy) begin
      if (start) begin
        if (level != m_pb) begin
          m_pb        = ~m_pb;
          m_busy      = 1'b1;
          k           = pickK(m_lfsr);
          m_remaining = 2 * k;
          if (k == 0) m_done_at = m_cyc + SC;
          else        m_next_toggle = m_cyc + pickSeg(m_lfsr);
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (m_remaining > 0 && m_cyc == m_next_toggle) begin
      m_pb = ~m_pb;
      m_remaining--;
      if (m_remaining == 0) m_done_at = m_cyc + SC;
      else                  m_next_toggle = m_cyc + pickSeg(m_lfsr);
    end else if (m_remaining == 0 && m_cyc == m_done_at) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    m_lfsr = lfsrNext(m_lfsr);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("pb_out", pb_out, m_pb);
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
  endtask

  task automatic doReset(input int n);
    rst = 1'b0;
    start = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_pb_out", pb_out, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    repeat (n) step();
    rst = 1'b1;
  endtask

  // One transition request. stray: 0 none, 1 random starts while busy,
  // 2 a single opposite-level start six cycles in. abort_at>0 resets mid-burst.
  task automatic applyStimulus(input logic lvl, input int stray, input int abort_at);
    logic prev;
    logic changed;
    int   edges;
    bit   finished;
    changed = (lvl != m_pb);
    prev    = pb_out;
    edges   = 0;
    start   = 1'b1;
    level   = lvl;
    step();
    start   = 1'b0;
    if (pb_out != prev) edges++;
    prev     = pb_out;
    finished = m_done;
    for (int n = 1; n < 400 && !finished; n++) begin
      if (stray == 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        level = 1'($urandom_range(0, 1));
      end else if (stray == 2 && n == 6) begin
        start = 1'b1;
        level = ~lvl;
      end
      step();
      start = 1'b0;
      level = lvl;
      if (pb_out != prev) edges++;
      prev = pb_out;
      if (abort_at != 0 && n == abort_at) begin
        doReset(2);
        return;
      end
      finished = m_done;
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);
    if (changed) begin
      checkOutput("edge_odd", 32'(edges % 2), 32'd1);
      checkOutput("edge_max", 32'(edges <= 2 * BM + 1), 32'd1);
      checkOutput("final_level", pb_out, lvl);
    end else begin
      checkOutput("no_edge", 32'(edges), 32'd0);
    end
  endtask

  initial begin
    m_cyc = 0;
    modelReset();
    doReset(3);
    $display("[TB] rise from reset");
    applyStimulus(1'b1, 0, 0);
    $display("[TB] same-level request");
    applyStimulus(1'b1, 0, 0);
    $display("[TB] start ignored while busy");
    applyStimulus(1'b0, 2, 0);
    applyStimulus(1'b1, 2, 0);
    $display("[TB] reset mid-bounce");
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 9);
    applyStimulus(1'b1, 0, 0);
    $display("[TB] random transitions");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'(i % 2), 1, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) step();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
